// File: rtl/map_scan.sv
// rtl/map_scan.sv - maze map sweep controller: streams every map cell downstream and classifies start/goal/walls
module map_scan #(
  parameter int CELLS = 100
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       scan_go,
  output logic       mem_re,
  output logic [6:0] mem_addr,
  input  logic [6:0] mem_rdata,
  output logic       in_do,
  output logic [6:0] now,
  output logic [6:0] map_block,
  output logic       busy,
  output logic       done,
  output logic [6:0] start_pos,
  output logic [6:0] goal_pos,
  output logic       start_found,
  output logic       goal_found,
  output logic [7:0] wall_cnt,
  output logic       err_multi
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);
  localparam logic [6:0] CODE_START = 7'h3F;
  localparam logic [6:0] CODE_GOAL  = 7'h00;

  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       rd_v_q, rd_v_d;
  logic [6:0] rd_idx_q, rd_idx_d;
  logic [6:0] start_pos_q, start_pos_d;
  logic [6:0] goal_pos_q, goal_pos_d;
  logic       start_found_q, start_found_d;
  logic       goal_found_q, goal_found_d;
  logic [7:0] wall_cnt_q, wall_cnt_d;
  logic       err_multi_q, err_multi_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_v_d        = 1'b0;
    rd_idx_d      = rd_idx_q;
    start_pos_d   = start_pos_q;
    goal_pos_d    = goal_pos_q;
    start_found_d = start_found_q;
    goal_found_d  = goal_found_q;
    wall_cnt_d    = wall_cnt_q;
    err_multi_d   = err_multi_q;

    case (state_q)
      S_IDLE: begin
        if (scan_go) begin
          state_d       = S_SCAN;
          cnt_d         = 7'd0;
          start_pos_d   = 7'd0;
          goal_pos_d    = 7'd0;
          start_found_d = 1'b0;
          goal_found_d  = 1'b0;
          wall_cnt_d    = 8'd0;
          err_multi_d   = 1'b0;
        end
      end
      S_SCAN: begin
        rd_v_d   = 1'b1;
        rd_idx_d = cnt_q;
        // Counter parks on the last address so mem_addr holds it after the sweep.
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read data returned this cycle belongs to rd_idx_q; only the first start/goal is kept.
    if (rd_v_q) begin
      if (mem_rdata == CODE_START) begin
        if (!start_found_q) begin
          start_pos_d   = rd_idx_q;
          start_found_d = 1'b1;
        end else begin
          err_multi_d = 1'b1;
        end
      end
      if (mem_rdata == CODE_GOAL) begin
        if (!goal_found_q) begin
          goal_pos_d   = rd_idx_q;
          goal_found_d = 1'b1;
        end else begin
          err_multi_d = 1'b1;
        end
      end
      if (mem_rdata[6]) begin
        wall_cnt_d = wall_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 7'd0;
      rd_v_q        <= 1'b0;
      rd_idx_q      <= 7'd0;
      start_pos_q   <= 7'd0;
      goal_pos_q    <= 7'd0;
      start_found_q <= 1'b0;
      goal_found_q  <= 1'b0;
      wall_cnt_q    <= 8'd0;
      err_multi_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_v_q        <= rd_v_d;
      rd_idx_q      <= rd_idx_d;
      start_pos_q   <= start_pos_d;
      goal_pos_q    <= goal_pos_d;
      start_found_q <= start_found_d;
      goal_found_q  <= goal_found_d;
      wall_cnt_q    <= wall_cnt_d;
      err_multi_q   <= err_multi_d;
    end
  end

  assign mem_re      = (state_q == S_SCAN);
  assign mem_addr    = cnt_q;
  assign in_do       = rd_v_q;
  assign now         = rd_v_q ? rd_idx_q : 7'd0;
  assign map_block   = rd_v_q ? mem_rdata : 7'd0;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign start_pos   = start_pos_q;
  assign goal_pos    = goal_pos_q;
  assign start_found = start_found_q;
  assign goal_found  = goal_found_q;
  assign wall_cnt    = wall_cnt_q;
  assign err_multi   = err_multi_q;

endmodule

// File: doc/map_scan.md
# map_scan

Upstream sweep controller for the maze cell classifier. On a `scan_go` pulse it reads every cell of the maze map RAM in address order. It presents each returned cell code to the downstream search stage as `map_block`/`now`/`in_do`. It also classifies the cells itself, capturing the start and goal positions, a wall count and a duplicate error, and reports completion with a one-cycle `done`.

## Interface
- CELLS, default 100: number of map cells swept, addresses 0..CELLS-1; legal range 1..128.
- m_clock  in  1  system clock; all state changes on its rising edge.
- p_reset  in  1  asynchronous, active-low reset; low forces all state to reset values immediately.
- scan_go  in  1  sweep request; sampled only in IDLE.
- mem_re  out  1  map RAM read enable.
- mem_addr  out  7  map RAM read address.
- mem_rdata  in  7  map RAM read data; valid exactly one cycle after `mem_re`.
- in_do  out  1  cell-valid strobe to the search stage.
- now  out  7  cell index matching `map_block`.
- map_block  out  7  cell code; equals `mem_rdata` when `in_do`=1, otherwise 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sweep end.
- start_pos  out  7  index of the first cell coded 7'h3F.
- goal_pos  out  7  index of the first cell coded 7'h00.
- start_found  out  1  at least one start cell seen.
- goal_found  out  1  at least one goal cell seen.
- wall_cnt  out  8  count of cells with code bit 6 = 1.
- err_multi  out  1  more than one start cell, or more than one goal cell, seen.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - `scan_go`=1 → SCAN.
  - Same edge clears `start_pos`, `goal_pos`, both found flags, `wall_cnt` and `err_multi`.
  - Loads the address counter with 0.
- SCAN:
  - `mem_re`=1 with `mem_addr` = counter; counter increments each cycle.
  - When counter = CELLS-1 is issued → DRAIN.
- DRAIN: `mem_re`=0; the last read returns this cycle → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Read pipeline:
  - A registered flag `rd_v` and a registered index `rd_idx` follow each issued read by one cycle.
  - `in_do` = `rd_v`; `now` = `rd_idx` when `rd_v`=1, else 0.
- Classification is performed in each `in_do` cycle and takes effect at the closing edge:
  - Code 7'h3F:
    - If `start_found`=0: `start_pos` ← `now`, `start_found` ← 1.
    - Otherwise `err_multi` ← 1 and `start_pos` is unchanged.
  - Code 7'h00: same rule using `goal_pos` and `goal_found`.
  - Code bit 6 = 1: `wall_cnt` +1. The 8-bit count cannot overflow, since CELLS ≤ 128.
  - Codes 7'h3F and 7'h00 have bit 6 = 0, so they never count as walls.
- Result outputs hold their values from the DONE cycle until the next accepted `scan_go`.
- `scan_go` outside IDLE is ignored. There is no queueing and no restart.
- `mem_addr` holds its last value when `mem_re`=0. Its value is 0 after reset.

## Timing
- Reset values: every output and all internal state are 0; the state is IDLE.
- Let `scan_go` be sampled at edge T. Then:
  - `mem_re`=1 with `mem_addr`=k in cycle T+1+k, for k = 0..CELLS-1.
  - `in_do`=1 with `now`=k in cycle T+2+k.
  - `done`=1 in cycle T+CELLS+2.
  - `busy`=1 from cycle T+1 through T+CELLS+2.
- The first `scan_go` after `done` can be accepted in the cycle immediately after `done`.
- `in_do` is continuous for CELLS cycles with no bubbles.
- Results are final and stable in the `done` cycle.
- CELLS=1 case: one read, one `in_do`, `done` at T+3.
- `p_reset` low mid-sweep:
  - `in_do`, `mem_re`, `busy` and `done` drop immediately.
  - All results clear.
  - No `done` is generated for the aborted sweep.
- Once reset is released, the block waits in IDLE for a new `scan_go`.

## Test plan
- Reset release, no `scan_go` for 20 cycles → all outputs 0 and `busy`=0 throughout.
- CELLS=100, map with cell 5 = 7'h3F, cell 93 = 7'h00, cells 10..19 = 7'h40, all others 7'h10:
  - `start_pos`=5, `goal_pos`=93, both found flags 1, `wall_cnt`=10, `err_multi`=0.
  - `done` exactly 102 cycles after the `scan_go` edge.
- Same map but cell 40 also = 7'h3F → `start_pos`=5, `err_multi`=1.
- Check `in_do` against the map:
  - `in_do` high for exactly 100 consecutive cycles.
  - `now` sequence 0..99, with each `map_block` equal to the RAM contents at that index.
- `scan_go` pulsed again at cycle 30 of a sweep → ignored; the single `done` arrives at the nominal cycle.
- `p_reset` driven low at cycle 50 of a sweep:
  - Outputs are 0 immediately and no `done` appears.
  - A fresh `scan_go` then completes with correct results.
